riscv_core_sc: RTL and testbench

- Single-cycle RV32I processor core: one instruction fetched, executed and retired per clock.
- Self-contained: owns its instruction memory, register file and data memory.
- Only ports are clock and reset. Programs are preloaded by the bench into the instruction memory by hierarchy.
- Observation is by hierarchy through the PC, register file and data memory.

---
 rtl/riscv_core_sc.sv | 225 ++++++++++++++++++++++
 tb/tb_riscv_core_sc.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_sc.sv
// Single-cycle RV32I core that owns its instruction memory, data memory and register file.
// Latency: every instruction is fetched, executed and retired on one clk rising edge.
// Backpressure: none; the core never stalls and takes one instruction per clock.
// Ports: clk (rising-edge clock for all state), rst (synchronous active-high reset).
// Programs are preloaded into instr_mem.mem by hierarchy; state is observed through pc, regs and data_mem.mem.

// Instruction ROM: word-addressed combinational read with no write port and no reset.
module riscv_core_sc_imem #(
  parameter int DEPTH = 10
) (
  input  logic [31:0] addr,
  output logic [31:0] rdata
);
  // Zero decodes as an unrecognised opcode, so unloaded words behave as NOPs.
  logic [31:0] mem [0:2**DEPTH-1] = '{default: '0};

  assign rdata = mem[addr[DEPTH+1:2]];

  // Upper bits wrap by truncation and the low two bits are ignored on fetch.
  logic unused_addr;
  assign unused_addr = ^{addr[31:DEPTH+2], addr[1:0]};
endmodule

// Data RAM: combinational read, byte-enabled write on the rising edge.
// Not cleared by reset, so contents survive it.
module riscv_core_sc_dmem #(
  parameter int DEPTH = 10
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        we,
  output logic [31:0] rdata
);
  logic [31:0]      mem [0:2**DEPTH-1];
  logic [DEPTH-1:0] idx;

  assign idx   = addr[DEPTH+1:2];
  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Lane selection inside the word is done by the core from addr[1:0].
  logic unused_addr;
  assign unused_addr = ^{addr[31:DEPTH+2], addr[1:0]};
endmodule

module riscv_core_sc #(
  parameter int          IMEM_DEPTH = 10,
  parameter int          DMEM_DEPTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc;
  logic [31:0] regs [0:31];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [31:0] alu_b, alu_out, sra_out;
  logic        alu_alt;
  logic        br_take;

  logic [31:0] mem_addr, mem_rdata, mem_wdata, ld_lane;
  logic [3:0]  mem_be, st_mask;
  logic        mem_we;

  logic [31:0] next_pc, rd_val;
  logic        rd_we;

  riscv_core_sc_imem #(.DEPTH(IMEM_DEPTH)) instr_mem (
    .addr  (pc),
    .rdata (instr)
  );

  // A reset edge aborts the instruction in flight, including its store.
  riscv_core_sc_dmem #(.DEPTH(DMEM_DEPTH)) data_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .be    (mem_be),
    .we    (mem_we & ~rst),
    .rdata (mem_rdata)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Bit 30 selects SUB/SRA for register ops; for immediates it is only an
  // opcode bit on SRAI, elsewhere it is part of the immediate value.
  assign alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
  assign alu_alt = (opcode == OP_REG) ? instr[30] : ((funct3 == 3'b101) && instr[30]);
  assign sra_out = $signed(rs1_val) >>> alu_b[4:0];

  always_comb begin
    alu_out = '0;
    case (funct3)
      3'b000: alu_out = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001: alu_out = rs1_val << alu_b[4:0];
      3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_out = {31'd0, rs1_val < alu_b};
      3'b100: alu_out = rs1_val ^ alu_b;
      3'b101: alu_out = alu_alt ? sra_out : (rs1_val >> alu_b[4:0]);
      3'b110: alu_out = rs1_val | alu_b;
      default: alu_out = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'b000: br_take = (rs1_val == rs2_val);
      3'b001: br_take = (rs1_val != rs2_val);
      3'b100: br_take = ($signed(rs1_val) < $signed(rs2_val));
      3'b101: br_take = !($signed(rs1_val) < $signed(rs2_val));
      3'b110: br_take = (rs1_val < rs2_val);
      3'b111: br_take = !(rs1_val < rs2_val);
      default: br_take = 1'b0;
    endcase
  end

  // Lanes are chosen from addr[1:0] by shifting; anything shifted past
  // lane 3 is dropped, so a halfword at offset 3 touches lane 3 only.
  assign mem_addr  = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign ld_lane   = mem_rdata >> {mem_addr[1:0], 3'b000};
  assign mem_wdata = rs2_val << {mem_addr[1:0], 3'b000};
  assign st_mask   = (funct3 == 3'b000) ? 4'b0001 :
                     (funct3 == 3'b001) ? 4'b0011 : 4'b1111;
  assign mem_be    = st_mask << mem_addr[1:0];

  always_comb begin
    next_pc = pc + 32'd4;
    rd_we   = 1'b0;
    rd_val  = '0;
    mem_we  = 1'b0;
    case (opcode)
      OP_LUI: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OP_AUIPC: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_val  = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rd_we   = 1'b1;
          rd_val  = pc + 32'd4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        if (br_take) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        case (funct3)
          3'b000: begin rd_we = 1'b1; rd_val = {{24{ld_lane[7]}}, ld_lane[7:0]}; end
          3'b001: begin rd_we = 1'b1; rd_val = {{16{ld_lane[15]}}, ld_lane[15:0]}; end
          3'b010: begin rd_we = 1'b1; rd_val = ld_lane; end
          3'b100: begin rd_we = 1'b1; rd_val = {24'd0, ld_lane[7:0]}; end
          3'b101: begin rd_we = 1'b1; rd_val = {16'd0, ld_lane[15:0]}; end
          default: rd_we = 1'b0;
        endcase
      end
      OP_STORE: begin
        mem_we = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OP_IMM, OP_REG: begin
        rd_we  = 1'b1;
        rd_val = alu_out;
      end
      default: ; // FENCE, SYSTEM and unknown opcodes retire as NOPs
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (rd_we && (rd != 5'd0)) regs[rd] <= rd_val;
    end
  end
endmodule

// File: tb/tb_riscv_core_sc.sv
// Bench for riscv_core_sc: random programs run in lockstep with an instruction-level model,
// plus directed programs for ALU, memory lanes, branch loop, jumps and mid-program reset.
// Programs are written into instr_mem.mem by hierarchy while reset is held.
module tb_riscv_core_sc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_core_sc #(.IMEM_DEPTH(10), .DMEM_DEPTH(10), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] prog [0:1023];
  int          plen;

  // Reference model state: architectural registers, PC and a byte-addressed memory.
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;
  logic [7:0]  m_mem  [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
    plen = 0;
  endtask

  task automatic add(input logic [31:0] w);
    prog[plen] = w;
    plen++;
  endtask

  task automatic load_imem();
    for (int i = 0; i < 1024; i++) dut.instr_mem.mem[i] = prog[i];
  endtask

  // ---------------- reference model ----------------
  task automatic wr(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 5'd0) m_regs[rd] = v;
  endtask

  function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, d, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d  = longint'(1) << b[4:0];
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return 32'(longint'(a) * d);
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (!alt) return 32'(longint'(a) / d);
        q = sa / d;
        if (sa < 0 && q * d != sa) q = q - 1;  // floor division
        return 32'(q);
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] in, a, b, immi, imms, immb, immu, immj, npc, ea, hw;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [11:0] ba;
    logic        take;
    longint      sa, sb;
    in   = prog[m_pc[11:2]];
    rd   = in[11:7];
    f3   = in[14:12];
    a    = m_regs[in[19:15]];
    b    = m_regs[in[24:20]];
    immi = 32'($signed(in[31:20]));
    imms = 32'($signed({in[31:25], in[11:7]}));
    immb = 32'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
    immu = {in[31:12], 12'd0};
    immj = 32'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
    npc  = m_pc + 32'd4;
    case (in[6:0])
      7'h37: wr(rd, immu);
      7'h17: wr(rd, m_pc + immu);
      7'h6f: begin wr(rd, m_pc + 32'd4); npc = m_pc + immj; end
      7'h67: if (f3 == 3'd0) begin npc = (a + immi) & ~32'h1; wr(rd, m_pc + 32'd4); end
      7'h63: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = (sa < sb);
          3'd5: take = (sa >= sb);
          3'd6: take = (a < b);
          3'd7: take = (a >= b);
          default: take = 1'b0;
        endcase
        if (take) npc = m_pc + immb;
      end
      7'h03: begin
        ea = a + immi;
        ba = ea[11:0];
        hw = {16'd0, m_mem[ba + 12'd1], m_mem[ba]};
        case (f3)
          3'd0: wr(rd, 32'($signed(m_mem[ba])));
          3'd1: wr(rd, 32'($signed(hw[15:0])));
          3'd2: wr(rd, {m_mem[ba + 12'd3], m_mem[ba + 12'd2], m_mem[ba + 12'd1], m_mem[ba]});
          3'd4: wr(rd, {24'd0, m_mem[ba]});
          3'd5: wr(rd, hw);
          default: ;
        endcase
      end
      7'h23: begin
        ea = a + imms;
        ba = ea[11:0];
        if (f3 <= 3'd2)
          for (int k = 0; k < (1 << f3); k++) m_mem[ba + 12'(k)] = b[8*k +: 8];
      end
      7'h13: wr(rd, m_alu(f3, (f3 == 3'd5) && in[30], a, immi));
      7'h33: wr(rd, m_alu(f3, in[30], a, b));
      default: ;
    endcase
    m_pc = npc;
  endtask

  // ---------------- sequencing helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two reset edges; the program is (re)loaded between them.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    step(1);
    chk({tag, " pc after 1st reset edge"}, dut.pc, 32'h0);
    load_imem();
    step(1);
    chk({tag, " pc after 2nd reset edge"}, dut.pc, 32'h0);
    for (int r = 0; r < 32; r++) chk($sformatf("%s reset x%0d", tag, r), dut.regs[r], 32'h0);
    rst = 1'b0;
    m_pc = 32'h0;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
  endtask

  task automatic run_lock(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      step(1);
      model_step();
      chk($sformatf("%s pc c%0d", tag, c), dut.pc, m_pc);
      for (int r = 0; r < 32; r++) chk($sformatf("%s x%0d c%0d", tag, r, c), dut.regs[r], m_regs[r]);
    end
  endtask

  task automatic cmp_dmem(input string tag);
    logic [31:0] exp;
    for (int w = 0; w < 256; w++) begin
      exp = {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
      chk($sformatf("%s dmem[%0d]", tag, w), dut.data_mem.mem[w], exp);
    end
  endtask

  task automatic build_random(input int n);
    int kind, f3, sz, off, rd;
    int ld_f3 [5]  = '{0, 1, 2, 4, 5};
    int br_f3 [6]  = '{0, 1, 4, 5, 6, 7};
    logic [31:0] nops [4] = '{32'h0000000F, 32'h00000073, 32'h00100073, 32'h30002573};
    clear_prog();
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 14);
      rd   = $urandom_range(0, 7);
      case (kind)
        0: add(enc_u($urandom, rd, 7'h37));
        1, 2, 3: begin
          f3 = $urandom_range(0, 7);
          if (f3 == 1)      off = $urandom_range(0, 31);
          else if (f3 == 5) off = $urandom_range(0, 31) + ($urandom_range(0, 1) * 32'h400);
          else              off = $urandom_range(0, 4095);
          add(enc_i(off, $urandom_range(0, 7), f3, rd, 7'h13));
        end
        4, 5, 6: begin
          f3 = $urandom_range(0, 7);
          add(enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0,
                    $urandom_range(0, 7), $urandom_range(0, 7), f3, rd));
        end
        7: add(enc_u($urandom, rd, 7'h17));
        8, 13: begin
          f3  = $urandom_range(0, 2);
          sz  = 1 << f3;
          off = $urandom_range(0, 255) & ~(sz - 1);
          add(enc_s(off, $urandom_range(0, 7), 0, f3));
        end
        9, 14: begin
          f3  = ld_f3[$urandom_range(0, 4)];
          sz  = 1 << (f3 % 4);
          off = $urandom_range(0, 255) & ~(sz - 1);
          add(enc_i(off, 0, f3, rd, 7'h03));
        end
        10: add(enc_b($urandom_range(2, 3) * 4, $urandom_range(0, 7), $urandom_range(0, 7),
                      br_f3[$urandom_range(0, 5)]));
        11: begin
          if ($urandom_range(0, 1) == 1) add(enc_j(8, rd));
          else add(enc_i(4 * i + 8 + $urandom_range(0, 1), 0, 0, rd, 7'h67));
        end
        default: begin
          if ($urandom_range(0, 4) == 4) add({$urandom_range(0, 33554431), 7'h0B});
          else add(nops[$urandom_range(0, 3)]);
        end
      endcase
    end
    repeat (3) add(32'h00000013);
    add(enc_j(0, 0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int w = 0; w < 1024; w++) dut.data_mem.mem[w] = 32'h0;
    for (int i = 0; i < 4096; i++) m_mem[i] = 8'h0;
    #1;

    // Random straight-line programs against the model.
    for (int t = 0; t < 2; t++) begin
      build_random(60);
      apply_reset($sformatf("rnd%0d", t));
      run_lock($sformatf("rnd%0d", t), 70);
      cmp_dmem($sformatf("rnd%0d", t));
    end

    // Store-heavy loop, reset while the SW is the current instruction.
    clear_prog();
    add(enc_i(0, 0, 0, 2, 7'h13));      // 00 ADDI x2,x0,0
    add(enc_i(1, 1, 0, 1, 7'h13));      // 04 ADDI x1,x1,1
    add(enc_s(64, 1, 2, 2));            // 08 SW x1,64(x2)
    add(enc_s(257, 1, 2, 0));           // 0C SB x1,257(x2)
    add(enc_s(386, 1, 2, 1));           // 10 SH x1,386(x2)
    add(enc_i(4, 2, 0, 2, 7'h13));      // 14 ADDI x2,x2,4
    add(enc_j(-20, 0));                 // 18 JAL x0,-20
    apply_reset("loop");
    run_lock("loop", 8);
    chk("loop pc at SW before reset", dut.pc, 32'h8);
    apply_reset("midrst");
    cmp_dmem("midrst");
    run_lock("restart", 40);
    cmp_dmem("restart");

    // ALU
    clear_prog();
    add(enc_i(5, 0, 0, 1, 7'h13));
    add(enc_i(-3, 0, 0, 2, 7'h13));
    add(enc_r(0, 2, 1, 0, 3));
    add(enc_r(32, 1, 2, 0, 4));
    add(enc_r(0, 1, 2, 2, 5));
    add(enc_r(0, 1, 2, 3, 6));
    add(enc_i(32'h401, 2, 5, 7, 7'h13));
    add(enc_i(7, 0, 0, 0, 7'h13));
    add(enc_j(0, 0));
    apply_reset("alu");
    step(1);
    chk("alu pc after first instr", dut.pc, 32'h4);
    step(7);
    chk("alu x3 add", dut.regs[3], 32'h2);
    chk("alu x4 sub", dut.regs[4], 32'hFFFF_FFF8);
    chk("alu x5 slt", dut.regs[5], 32'h1);
    chk("alu x6 sltu", dut.regs[6], 32'h0);
    chk("alu x7 srai", dut.regs[7], 32'hFFFF_FFFE);
    chk("alu x0 stays 0", dut.regs[0], 32'h0);
    step(1);
    chk("alu pc self loop", dut.pc, 32'h20);

    // Memory lanes
    clear_prog();
    add(enc_u(32'h12345, 1, 7'h37));    // 00 LUI x1,0x12345
    add(enc_i(32'h678, 1, 0, 1, 7'h13));// 04 ADDI x1,x1,0x678
    add(enc_s(8, 1, 0, 2));             // 08 SW x1,8(x0)
    add(enc_s(9, 0, 0, 0));             // 0C SB x0,9(x0)
    add(enc_i(8, 0, 2, 2, 7'h03));      // 10 LW x2,8(x0)
    add(enc_i(8, 0, 0, 3, 7'h03));      // 14 LB x3,8(x0)
    add(enc_i(10, 0, 5, 4, 7'h03));     // 18 LHU x4,10(x0)
    add(enc_i(11, 0, 1, 5, 7'h03));     // 1C LH x5,11(x0)
    add(enc_s(32'h323, 1, 0, 1));       // 20 SH x1,0x323(x0)
    add(enc_i(32'h323, 0, 1, 6, 7'h03));// 24 LH x6,0x323(x0)
    add(enc_u(1, 8, 7'h37));            // 28 LUI x8,1
    add(enc_i(8, 8, 2, 9, 7'h03));      // 2C LW x9,8(x8)
    add(enc_j(0, 0));                   // 30 JAL x0,0
    apply_reset("mem");
    step(12);
    chk("mem dmem[2]", dut.data_mem.mem[2], 32'h1234_0078);
    chk("mem x2 lw", dut.regs[2], 32'h1234_0078);
    chk("mem x3 lb", dut.regs[3], 32'h0000_0078);
    chk("mem x4 lhu", dut.regs[4], 32'h0000_1234);
    chk("mem x5 lh off3", dut.regs[5], 32'h0000_0012);
    chk("mem dmem[200] sh off3", dut.data_mem.mem[200], 32'h7800_0000);
    chk("mem x6 lh off3", dut.regs[6], 32'h0000_0078);
    chk("mem x9 wrapped lw", dut.regs[9], 32'h1234_0078);
    chk("mem pc", dut.pc, 32'h30);

    // Branch loop
    clear_prog();
    add(enc_i(3, 0, 0, 1, 7'h13));
    add(enc_i(-1, 1, 0, 1, 7'h13));
    add(enc_b(-4, 0, 1, 1));
    add(enc_i(9, 0, 0, 2, 7'h13));
    add(enc_j(0, 0));
    apply_reset("br");
    step(3);
    chk("br pc after taken bne", dut.pc, 32'h4);
    step(4);
    chk("br pc after fallthrough", dut.pc, 32'hC);
    chk("br x2 before addi", dut.regs[2], 32'h0);
    step(1);
    chk("br x1", dut.regs[1], 32'h0);
    chk("br x2", dut.regs[2], 32'h9);
    chk("br pc end", dut.pc, 32'h10);

    // Jumps
    clear_prog();
    repeat (4) add(32'h00000013);
    add(enc_j(8, 1));                   // 10 JAL x1,+8
    add(enc_u(1, 5, 7'h17));            // 14 AUIPC x5,1
    add(enc_i(0, 1, 0, 0, 7'h67));      // 18 JALR x0,0(x1)
    apply_reset("jmp");
    step(5);
    chk("jmp jal link", dut.regs[1], 32'h14);
    chk("jmp jal pc", dut.pc, 32'h18);
    step(1);
    chk("jmp jalr pc", dut.pc, 32'h14);
    step(1);
    chk("jmp auipc x5", dut.regs[5], 32'h1014);
    chk("jmp pc after auipc", dut.pc, 32'h18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
